// File: rtl/rom_port_responder.sv
// rtl/rom_port_responder.sv - ROM chip bus responder with one 4-bit I/O port
module rom_port_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  input  logic       rom_cmd,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_en,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_t;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  phase_t     phase_q, phase_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [3:0] io_out_q, io_out_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic       selected_q, selected_d;
  logic       src_selected_q, src_selected_d;
  logic       io_pending_q, io_pending_d;
  logic       port_op;

  // Port op qualifies on the instruction latched this cycle and the last SRC target.
  assign port_op = io_pending_q && src_selected_q && (opr_q == OPR_IO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q        <= PH_IDLE;
      rom_addr_q     <= 8'h00;
      io_out_q       <= 4'h0;
      opr_q          <= 4'h0;
      opa_q          <= 4'h0;
      selected_q     <= 1'b0;
      src_selected_q <= 1'b0;
      io_pending_q   <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      rom_addr_q     <= rom_addr_d;
      io_out_q       <= io_out_d;
      opr_q          <= opr_d;
      opa_q          <= opa_d;
      selected_q     <= selected_d;
      src_selected_q <= src_selected_d;
      io_pending_q   <= io_pending_d;
    end
  end

  always_comb begin
    phase_d        = phase_q;
    rom_addr_d     = rom_addr_q;
    io_out_d       = io_out_q;
    opr_d          = opr_q;
    opa_d          = opa_q;
    selected_d     = selected_q;
    src_selected_d = src_selected_q;
    io_pending_d   = io_pending_q;
    case (phase_q)
      PH_IDLE: begin
        if (sync) phase_d = PH_A1;
      end
      PH_X3: begin
        phase_d      = sync ? PH_A1 : PH_IDLE;
        io_pending_d = 1'b0;
      end
      default: begin
        if (sync) begin
          // Resync mid-cycle: restart at A1 and drop any fetch selection.
          phase_d    = PH_A1;
          selected_d = 1'b0;
        end else begin
          phase_d = phase_t'(phase_q + 4'd1);
          case (phase_q)
            PH_A1: rom_addr_d[3:0] = data_i;
            PH_A2: rom_addr_d[7:4] = data_i;
            PH_A3: selected_d = rom_cmd && (data_i == CHIP_ID);
            PH_M1: opr_d = data_i;
            PH_M2: begin
              opa_d        = data_i;
              io_pending_d = rom_cmd;
            end
            PH_X2: begin
              if (rom_cmd) begin
                src_selected_d = (data_i == CHIP_ID);
              end else if (port_op && (opa_q == OPA_WRR)) begin
                io_out_d = data_i;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    data_en = 1'b0;
    data_o  = 4'h0;
    case (phase_q)
      PH_M1: if (selected_q) begin
        data_en = 1'b1;
        data_o  = rom_data[7:4];
      end
      PH_M2: if (selected_q) begin
        data_en = 1'b1;
        data_o  = rom_data[3:0];
      end
      PH_X2: if (port_op && (opa_q == OPA_RDR)) begin
        data_en = 1'b1;
        data_o  = io_in;
      end
      default: ;
    endcase
  end

  assign rom_addr = rom_addr_q;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_rom_port_responder.sv
// tb/tb_rom_port_responder.sv - instruction-cycle level reference checks for rom_port_responder
module tb_rom_port_responder;

  localparam logic [3:0] ID = 4'h3;

  logic       clock = 1'b0;
  logic       reset;
  logic       sync;
  logic       rom_cmd;
  logic [3:0] cpu_d;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [7:0] mem [256];

  always #5 clock = ~clock;

  // Shared bus: the responder's nibble wins when it drives, otherwise the CPU's.
  assign data_i   = data_en ? data_o : cpu_d;
  assign rom_data = mem[rom_addr];

  rom_port_responder #(.CHIP_ID(ID)) dut (
    .clock(clock), .reset(reset), .sync(sync), .rom_cmd(rom_cmd),
    .data_i(data_i), .data_o(data_o), .data_en(data_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .io_in(io_in), .io_out(io_out)
  );

  int checks = 0;
  int errors = 0;

  logic       chk = 1'b0;
  int         cur_ph = 0;
  logic       exp_en;
  logic [3:0] exp_o;
  logic [7:0] exp_addr;
  logic [3:0] exp_io;
  logic       cap_en [9];
  logic [3:0] cap_o  [9];

  logic [7:0] m_addr;
  logic       m_sel, m_src, m_pend;
  logic [3:0] m_opr, m_opa, m_io;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk && !reset) begin
      check("data_en", {7'b0, data_en}, {7'b0, exp_en});
      check("data_o", {4'b0, data_o}, {4'b0, exp_o});
      check("rom_addr", rom_addr, exp_addr);
      check("io_out", {4'b0, io_out}, {4'b0, exp_io});
      cap_en[cur_ph] = data_en;
      cap_o[cur_ph]  = data_o;
    end
  end

  task automatic model_reset();
    m_addr = 8'h00; m_sel = 0; m_src = 0; m_pend = 0;
    m_opr = 4'h0; m_opa = 4'h0; m_io = 4'h0;
  endtask

  task automatic phase(input int ph, input logic s, input logic cmd, input logic [3:0] d,
                       input logic en, input logic [3:0] o);
    sync = s; rom_cmd = cmd; cpu_d = d; cur_ph = ph;
    exp_en = en; exp_o = en ? o : 4'h0; exp_addr = m_addr; exp_io = m_io; chk = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic kick();
    phase(0, 1'b1, 1'b0, 4'($urandom), 1'b0, 4'h0);
  endtask

  task automatic idle_phases(input int n);
    for (int i = 0; i < n; i++) phase(0, 1'b0, 1'($urandom), 4'($urandom), 1'b0, 4'h0);
  endtask

  // One whole instruction cycle from A1 through X3, expectations derived from the cycle's inputs.
  task automatic run_cycle(input logic [3:0] a_lo, input logic [3:0] a_hi, input logic [3:0] chip,
                           input logic cmd_a3, input logic [3:0] m1, input logic [3:0] m2,
                           input logic cmd_m2, input logic [3:0] x2v, input logic cmd_x2,
                           input logic sync_end, input logic resync_m1, input logic rst_m2);
    logic [7:0] op;
    logic       rdr, cx2;
    phase(1, 1'b0, 1'b0, a_lo, 1'b0, 4'h0); m_addr[3:0] = a_lo;
    phase(2, 1'b0, 1'b0, a_hi, 1'b0, 4'h0); m_addr[7:4] = a_hi;
    phase(3, 1'b0, cmd_a3, chip, 1'b0, 4'h0); m_sel = cmd_a3 && (chip == ID);
    op = mem[m_addr];
    if (resync_m1) begin
      phase(4, 1'b1, 1'b0, m1, m_sel, op[7:4]);
      m_sel = 1'b0;
      return;
    end
    phase(4, 1'b0, 1'b0, m1, m_sel, op[7:4]); m_opr = m_sel ? op[7:4] : m1;
    if (rst_m2) begin
      sync = 0; rom_cmd = cmd_m2; cpu_d = m2; cur_ph = 5;
      exp_en = m_sel; exp_o = m_sel ? op[3:0] : 4'h0; exp_addr = m_addr; exp_io = m_io; chk = 1'b1;
      @(negedge clock); #1;
      chk = 1'b0; reset = 1'b1; #1;
      check("rst_data_en", {7'b0, data_en}, 8'h00);
      check("rst_io_out", {4'b0, io_out}, 8'h00);
      check("rst_rom_addr", rom_addr, 8'h00);
      @(posedge clock); #1;
      check("rst_hold_data_en", {7'b0, data_en}, 8'h00);
      reset = 1'b0;
      model_reset();
      return;
    end
    phase(5, 1'b0, cmd_m2, m2, m_sel, op[3:0]); m_opa = m_sel ? op[3:0] : m2; m_pend = cmd_m2;
    phase(6, 1'b0, 1'b0, 4'($urandom), 1'b0, 4'h0);
    cx2 = cmd_x2;
    if (m_pend && m_src && m_opr == 4'hE && m_opa == 4'hA) cx2 = 1'b0;
    rdr = !cx2 && m_pend && m_src && m_opr == 4'hE && m_opa == 4'hA;
    phase(7, 1'b0, cx2, x2v, rdr, io_in);
    if (cx2) m_src = (x2v == ID);
    else if (m_pend && m_src && m_opr == 4'hE && m_opa == 4'h2) m_io = x2v;
    phase(8, sync_end, 1'b0, 4'($urandom), 1'b0, 4'h0);
    m_pend = 1'b0;
  endtask

  initial begin
    logic [3:0] a_lo, a_hi, chip, m1, m2, x2v;
    logic       cmd_a3, cmd_m2, cmd_x2, se;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 5))
        0: mem[i] = 8'hE2;
        1: mem[i] = 8'hEA;
        default: mem[i] = 8'($urandom);
      endcase
    end
    mem[8'h5A] = 8'hD7;
    reset = 1'b1; sync = 0; rom_cmd = 0; cpu_d = 4'h0; io_in = 4'h0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_data_en", {7'b0, data_en}, 8'h00);
    check("reset_data_o", {4'b0, data_o}, 8'h00);
    check("reset_rom_addr", rom_addr, 8'h00);
    check("reset_io_out", {4'b0, io_out}, 8'h00);
    reset = 1'b0;
    idle_phases(2);

    // Fetch hit at 0x5A, then a miss on chip 2
    kick();
    run_cycle(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 0);
    check("hit_m1_en", {7'b0, cap_en[4]}, 8'h01);
    check("hit_m1_o", {4'b0, cap_o[4]}, 8'h0D);
    check("hit_m2_o", {4'b0, cap_o[5]}, 8'h07);
    check("hit_x2_en", {7'b0, cap_en[7]}, 8'h00);
    run_cycle(4'hA, 4'h5, 4'h2, 1, 4'h1, 4'h1, 0, 4'h0, 0, 1, 0, 0);
    check("miss_m1_en", {7'b0, cap_en[4]}, 8'h00);
    check("miss_m2_en", {7'b0, cap_en[5]}, 8'h00);
    check("miss_rom_addr", rom_addr, 8'h5A);

    // SRC to this chip then WRR 9; SRC elsewhere then WRR 5 leaves port alone
    run_cycle(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h3, 1, 1, 0, 0);
    run_cycle(4'h1, 4'h1, 4'h0, 0, 4'hE, 4'h2, 1, 4'h9, 0, 1, 0, 0);
    check("wrr_io_out", {4'b0, io_out}, 8'h09);
    run_cycle(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h1, 1, 1, 0, 0);
    run_cycle(4'h1, 4'h1, 4'h0, 0, 4'hE, 4'h2, 1, 4'h5, 0, 1, 0, 0);
    check("wrr_other_io_out", {4'b0, io_out}, 8'h09);

    // RDR after SRC selects this chip
    run_cycle(4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 4'h3, 1, 1, 0, 0);
    io_in = 4'hC;
    run_cycle(4'h2, 4'h2, 4'h0, 0, 4'hE, 4'hA, 1, 4'h0, 0, 1, 0, 0);
    check("rdr_x2_en", {7'b0, cap_en[7]}, 8'h01);
    check("rdr_x2_o", {4'b0, cap_o[7]}, 8'h0C);
    check("rdr_x1_en", {7'b0, cap_en[6]}, 8'h00);
    check("rdr_x3_en", {7'b0, cap_en[8]}, 8'h00);

    // No sync at X3 drops to idle; sync at M1 restarts at A1
    run_cycle(4'h4, 4'h4, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0);
    idle_phases(16);
    kick();
    run_cycle(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0);
    run_cycle(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 0);
    check("resync_fetch_o", {4'b0, cap_o[4]}, 8'h0D);

    // Async reset during M2 of a hit, then a fresh fetch
    run_cycle(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 1);
    idle_phases(2);
    kick();
    run_cycle(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 0);
    check("post_reset_m1_o", {4'b0, cap_o[4]}, 8'h0D);
    check("post_reset_m2_o", {4'b0, cap_o[5]}, 8'h07);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      a_lo = 4'($urandom); a_hi = 4'($urandom);
      chip = $urandom_range(0, 1) ? ID : 4'($urandom);
      cmd_a3 = ($urandom_range(0, 3) != 0);
      m1 = $urandom_range(0, 1) ? 4'hE : 4'($urandom);
      case ($urandom_range(0, 2))
        0: m2 = 4'h2;
        1: m2 = 4'hA;
        default: m2 = 4'($urandom);
      endcase
      cmd_m2 = 1'($urandom);
      x2v = $urandom_range(0, 1) ? ID : 4'($urandom);
      cmd_x2 = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 9) != 0);
      io_in = 4'($urandom);
      run_cycle(a_lo, a_hi, chip, cmd_a3, m1, m2, cmd_m2, x2v, cmd_x2, se, 0, 0);
      if (!se) begin
        idle_phases($urandom_range(1, 4));
        kick();
      end
    end
    chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_port_responder.md
# rom_port_responder

Bus-side responder for the 4-bit CPU's instruction bus: one ROM chip plus its 4-bit I/O port. It tracks the CPU's eight-phase instruction cycle using `sync`. It latches the 8-bit fetch address the CPU drives, and returns the addressed opcode byte in two nibbles when its chip number is selected. It also executes the SRC/WRR/RDR port operations. It sits between the CPU's `data_i/data_o/data_en/sync/rom_cmd` pins and an external combinational byte store.

## Interface
- `CHIP_ID`, default 4'h0, chip number matched at A3 (fetch select) and X2 (SRC select).
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sync`  in  1  CPU cycle marker, high during X3 (last phase of a cycle).
- `rom_cmd`  in  1  CPU ROM command strobe, sampled at A3, M2, X2.
- `data_i`  in  4  shared bus value (CPU `data_o` when CPU `data_en`, else responder output).
- `data_o`  out  4  nibble driven by this block; 4'h0 when `data_en` low.
- `data_en`  out  1  this block drives the bus this phase.
- `rom_addr`  out  8  latched fetch address to byte store.
- `rom_data`  in  8  byte store read data, combinational from `rom_addr`.
- `io_in`  in  4  input port pins, read by RDR.
- `io_out`  out  4  registered output port, written by WRR.

## Operation
- Phase register: IDLE, A1, A2, A3, M1, M2, X1, X2, X3. One phase per clock.
- IDLE→A1 only when `sync`=1 at an edge.
- A1→A2→…→X3 unconditionally, one step per edge.
- From X3: next is A1 if `sync`=1, else IDLE.
- `sync`=1 in any phase other than X3 or IDLE is a resync. Next phase is A1, and `selected` is cleared.
- A1 edge: `rom_addr[3:0]`<=`data_i`.
- A2 edge: `rom_addr[7:4]`<=`data_i`.
- A3 edge: `selected`<= `rom_cmd` && (`data_i`==`CHIP_ID`).
- M1 phase: if `selected`, `data_en`=1 and `data_o`=`rom_data[7:4]`.
- M1 edge: `opr`<=`data_i`.
- M2 phase: if `selected`, `data_en`=1 and `data_o`=`rom_data[3:0]`.
- M2 edge: `opa`<=`data_i`; `io_pending`<=`rom_cmd`.
- X2 phase, `rom_cmd`=1 (SRC): at the edge, `src_selected`<=(`data_i`==`CHIP_ID`). No port action.
- X2 phase, `rom_cmd`=0, `io_pending`, `src_selected`, `opr`=4'hE:
  - `opa`=4'h2 (WRR): `io_out`<=`data_i` at the edge.
  - `opa`=4'hA (RDR): `data_en`=1 and `data_o`=`io_in` during X2.
  - Any other `opa`: no action.
- X3 edge: `io_pending`<=0. `selected` and `src_selected` persist; `src_selected` persists until the next SRC.
- `data_o`/`data_en` are combinational from phase and registered state. The only other input on that path is `io_in`, used during RDR.
- Reset values: phase=IDLE, `data_en`=0, `data_o`=0, `rom_addr`=0, `io_out`=0, `selected`=0, `src_selected`=0, `io_pending`=0, `opr`=`opa`=0.

## Timing
- Address-to-data latency: `rom_addr` is complete after the A2 edge. Opcode nibbles are presented in M1 and M2, two and three clocks after A2. The byte store must settle within one clock.
- The CPU samples the opcode at the M1 and M2 edges. This block holds `data_en` for exactly those phases, plus X2 for RDR.
- WRR result is visible on `io_out` the clock after the X2 edge.
- `sync` and the X3→A1 transition happen on the same edge. Back-to-back cycles have no gap.
- Reset asserted mid-cycle: outputs go to reset values immediately, with no wait for a clock. After release, the block stays IDLE until `sync`.
- Unselected chip: `data_en`=0 in all phases. It still tracks `opr`/`opa` so it can execute port ops when it is the SRC target.
- `rom_addr` wraps naturally; 8'hFF is legal, with no carry into the chip number.

## Test plan
- Fetch hit, `CHIP_ID`=3, store[8'h5A]=8'hD7:
  - Stimulus: `sync` pulse, then bus 4'hA, 4'h5, 4'h3 with `rom_cmd`=1 at A3.
  - Required: `data_en`=1 with `data_o`=4'hD in M1 and 4'h7 in M2; `data_en`=0 elsewhere.
- Fetch miss: same as fetch hit, but chip nibble 4'h2 at A3.
  - Required: `data_en`=0 for the whole cycle; `rom_addr`=8'h5A.
- SRC then WRR:
  - Stimulus: cycle with X2 `rom_cmd`=1 and bus 4'h3; next cycle M1 bus 4'hE, M2 bus 4'h2 with `rom_cmd`=1, X2 bus 4'h9.
  - Required: `io_out`=4'h9 after the X2 edge.
  - Variant: SRC to chip 4'h1 → `io_out` unchanged.
- RDR: after SRC selects this chip, instruction E/A with `io_in`=4'hC.
  - Required: `data_en`=1 and `data_o`=4'hC in X2 only.
- Sync discipline: cycle with no `sync` at X3 → IDLE, `data_en`=0 for 16 clocks. `sync` at M1 → next phase A1, `selected` cleared.
- Async reset asserted during M2 of a hit cycle:
  - Required: `data_en`=0 and `io_out`=0 before the next edge.
  - After release, a normal `sync`-started fetch works.
